// File: rtl/mem_seq_pkg.sv
// Shared types and defaults for the memory write sequencer and its helpers.
package mem_seq_pkg;

   localparam int DEFAULT_DEPTH = 256;
   localparam int DIN_W         = 20;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE
   } seq_state_e;

endpackage

// File: rtl/wrap_addr_counter.sv
// Address pointer that counts modulo DEPTH; a load takes priority over an increment.
module wrap_addr_counter
   import mem_seq_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          inc,
   input  logic [AW-1:0] load_value,
   output logic [AW-1:0] value
);

   logic [AW-1:0] value_reg;

   // Explicit wrap so non-power-of-two depths also stay in range.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_reg <= '0;
      end else if (load) begin
         value_reg <= load_value;
      end else if (inc) begin
         if (value_reg == AW'(DEPTH - 1))
            value_reg <= '0;
         else
            value_reg <= value_reg + AW'(1);
      end
   end

   assign value = value_reg;

endmodule

// File: rtl/mem_write_sequencer.sv
// Turns a start/base/length command plus a valid/ready word stream into a run of
// registered single-cycle writes on consecutive (wrapping) memory addresses.
module mem_write_sequencer
   import mem_seq_pkg::*;
#(
   parameter int  DEPTH = DEFAULT_DEPTH,
   parameter int  DIN_W = mem_seq_pkg::DIN_W,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [AW-1:0]    base_addr,
   input  logic [AW:0]      length,
   input  logic             abort,
   input  logic [DIN_W-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             mem_full,
   output logic [AW-1:0]    mem_address,
   output logic [DIN_W-1:0] mem_datain,
   output logic             mem_write_en,
   output logic             busy,
   output logic             done,
   output logic [AW:0]      word_count
);

   seq_state_e       state_reg, state_next;
   logic [AW:0]      target_reg;
   logic [AW:0]      word_count_reg;
   logic [AW:0]      count_inc;
   logic [AW-1:0]    ptr_value;
   logic [AW-1:0]    mem_address_reg;
   logic [DIN_W-1:0] mem_datain_reg;
   logic             mem_write_en_reg;
   logic             accept_start;
   logic             beat;

   assign count_inc = word_count_reg + {{AW{1'b0}}, 1'b1};

   wrap_addr_counter #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ptr (
      .clk        (clk),
      .rst        (rst),
      .load       (accept_start),
      .inc        (beat),
      .load_value (base_addr),
      .value      (ptr_value)
   );

   // Abort outranks a beat in the same cycle: that word is neither written nor counted.
   always_comb begin
      state_next   = state_reg;
      accept_start = 1'b0;
      beat         = 1'b0;
      in_ready     = (state_reg == LOAD) && !mem_full;
      case (state_reg)
         IDLE: begin
            if (start) begin
               accept_start = 1'b1;
               state_next   = (length == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            if (abort) begin
               state_next = IDLE;
            end else if (in_valid && in_ready) begin
               beat = 1'b1;
               if (count_inc == target_reg)
                  state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= IDLE;
         target_reg       <= '0;
         word_count_reg   <= '0;
         mem_address_reg  <= '0;
         mem_datain_reg   <= '0;
         mem_write_en_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept_start) begin
            target_reg     <= length;
            word_count_reg <= '0;
         end
         if (beat) begin
            word_count_reg   <= count_inc;
            mem_address_reg  <= ptr_value;
            mem_datain_reg   <= in_data;
            mem_write_en_reg <= 1'b1;
         end else begin
            mem_write_en_reg <= 1'b0;
         end
      end
   end

   assign mem_address  = mem_address_reg;
   assign mem_datain   = mem_datain_reg;
   assign mem_write_en = mem_write_en_reg;
   assign word_count   = word_count_reg;
   assign done         = (state_reg == DONE);
   assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_write_sequencer.sv
// Directed test-plan scenarios followed by random traffic, all checked cycle by
// cycle against a run-level reference model (address = base + count mod DEPTH).
module tb_mem_write_sequencer;

   localparam int DEPTH = 256;
   localparam int AW    = 8;
   localparam int DW    = 20;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          abort;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          mem_full;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_datain;
   logic          mem_write_en;
   logic          busy;
   logic          done;
   logic [AW:0]   word_count;

   always #5 clk = ~clk;

   mem_write_sequencer #(.DEPTH(DEPTH), .DIN_W(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .base_addr    (base_addr),
      .length       (length),
      .abort        (abort),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .mem_full     (mem_full),
      .mem_address  (mem_address),
      .mem_datain   (mem_datain),
      .mem_write_en (mem_write_en),
      .busy         (busy),
      .done         (done),
      .word_count   (word_count)
   );

   int vectors = 0;
   int errors  = 0;

   // Reference model: a run is either in progress, just completed, or absent.
   bit m_run    = 0;
   bit m_done   = 0;
   int m_base   = 0;
   int m_target = 0;
   int m_count  = 0;
   bit exp_we   = 0;
   int exp_addr = 0;
   int exp_data = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_run = 0; m_done = 0; m_base = 0; m_target = 0; m_count = 0;
         exp_we = 0; exp_addr = 0; exp_data = 0;
      end else begin
         exp_we = 0;
         if (m_done) begin
            m_done = 0;
         end else if (m_run) begin
            if (abort) begin
               m_run = 0;
            end else if (in_valid && !mem_full) begin
               exp_addr = (m_base + m_count) % DEPTH;
               exp_data = int'(in_data);
               exp_we   = 1;
               m_count++;
               if (m_count == m_target) begin
                  m_run  = 0;
                  m_done = 1;
               end
            end
         end else if (start) begin
            m_base   = int'(base_addr);
            m_target = int'(length);
            m_count  = 0;
            if (m_target == 0) m_done = 1;
            else               m_run  = 1;
         end
      end
   endtask

   task automatic step();
      #3;
      check_eq("in_ready", 32'(in_ready), 32'(m_run && !mem_full));
      model_edge();
      @(posedge clk);
      #1;
      check_eq("mem_write_en", 32'(mem_write_en), 32'(exp_we));
      check_eq("mem_address", 32'(mem_address), 32'(exp_addr));
      check_eq("mem_datain", 32'(mem_datain), 32'(exp_data));
      check_eq("done", 32'(done), 32'(m_done));
      check_eq("busy", 32'(busy), 32'(m_run || m_done));
      check_eq("word_count", 32'(word_count), 32'(m_count));
      if (mem_write_en)
         $display("write addr=%02h data=%05h count=%0d done=%0b", mem_address, mem_datain, word_count, done);
   endtask

   task automatic cmd(input int base, input int len);
      start     = 1'b1;
      base_addr = AW'(base);
      length    = (AW+1)'(len);
      step();
      start = 1'b0;
   endtask

   task automatic feed(input int d);
      in_valid = 1'b1;
      in_data  = DW'(d);
      step();
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; abort = 1'b0;
      in_data = '0; in_valid = 1'b0; mem_full = 1'b0;
      @(posedge clk);
      #1;
      step();
      rst = 1'b0;

      // Basic run
      cmd('h10, 4);
      for (int i = 1; i <= 4; i++) feed('hA0000 + i);
      check_eq("basic_done", 32'(done), 32'd1);
      idle_cycle();
      check_eq("basic_wc", 32'(word_count), 32'd4);

      // Wrap-around
      cmd('hFE, 4);
      for (int i = 0; i < 3; i++) feed('hB0000 + i);
      check_eq("wrap_addr", 32'(mem_address), 32'h00);
      feed('hB0003);
      idle_cycle();

      // Backpressure
      cmd('h40, 5);
      feed('hC0001);
      feed('hC0002);
      mem_full = 1'b1;
      for (int i = 0; i < 3; i++) feed('hC0003);
      mem_full = 1'b0;
      for (int i = 3; i <= 5; i++) feed('hC0000 + i);
      idle_cycle();
      check_eq("bp_wc", 32'(word_count), 32'd5);

      // Zero length
      cmd('h20, 0);
      check_eq("len0_done", 32'(done), 32'd1);
      idle_cycle();

      // Start during a run
      cmd('h30, 4);
      feed('hD0001);
      start = 1'b1; base_addr = 8'h90; length = 9'd2;
      feed('hD0002);
      start = 1'b0;
      feed('hD0003);
      feed('hD0004);
      check_eq("midstart_addr", 32'(mem_address), 32'h33);
      idle_cycle();

      // Abort on the 3rd beat
      cmd('h50, 8);
      feed('hE0001);
      feed('hE0002);
      abort = 1'b1;
      feed('hE0003);
      abort = 1'b0;
      idle_cycle();
      check_eq("abort_wc", 32'(word_count), 32'd2);
      check_eq("abort_busy", 32'(busy), 32'd0);

      // Reset on the 3rd beat, then a clean run
      cmd('h60, 6);
      feed('hF0001);
      feed('hF0002);
      rst = 1'b1;
      feed('hF0003);
      rst = 1'b0;
      check_eq("rst_we", 32'(mem_write_en), 32'd0);
      idle_cycle();
      cmd('h70, 2);
      feed('h12345);
      feed('h23456);
      idle_cycle();

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         rst       = ($urandom_range(0, 299) == 0);
         start     = ($urandom_range(0, 2) == 0);
         base_addr = AW'($urandom_range(0, DEPTH - 1));
         length    = ($urandom_range(0, 24) == 0) ? (AW+1)'(DEPTH) : (AW+1)'($urandom_range(0, 12));
         abort     = ($urandom_range(0, 39) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = DW'($urandom);
         mem_full  = ($urandom_range(0, 4) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
